// File: rtl/rs232_avmm_responder_pkg.sv
// Shared definitions for the RS232 Avalon-MM responder: register map, status
// bit positions, bus FSM states and the latched request record.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'h00;
  localparam logic [4:0] TX_BASE     = 5'h04;
  localparam logic [4:0] STATUS_BASE = 5'h08;

  localparam int TX_OK_BIT  = 6;
  localparam int RX_OK_BIT  = 7;
  localparam int RX_OVF_BIT = 8;
  localparam int TX_OVF_BIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] addr;
    logic       rd;
    logic       wr;
  } req_t;

  function automatic logic [31:0] status_word(input logic rx_ok, input logic tx_ok,
                                              input logic rx_ovf, input logic tx_ovf);
    logic [31:0] w;
    w             = '0;
    w[RX_OK_BIT]  = rx_ok;
    w[TX_OK_BIT]  = tx_ok;
    w[RX_OVF_BIT] = rx_ovf;
    w[TX_OVF_BIT] = tx_ovf;
    return w;
  endfunction

endpackage

// File: rtl/rs232_avmm_responder_byte_fifo.sv
// Byte-wide synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; resetting the pointers is enough to flush it,
  // and head_o is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/rs232_avmm_responder.sv
// Avalon-MM slave exposing an RS232-style register map (RX data, TX data,
// status) over two byte FIFOs, with a programmable waitrequest delay.
module rs232_avmm_responder
  import rs232_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d, bus_req;
  logic        bus_active;
  logic        enter_ack;
  logic        commit;

  logic [31:0] readdata_q, readdata_d, read_value;
  logic        rx_pop_q, rx_pop_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        tx_ovf_q, tx_ovf_d;

  logic        wr_commit, stat_clr;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  rx_head, tx_head;
  logic        unused_wdata;

  assign bus_req      = '{addr: avm_address, rd: avm_read, wr: avm_write};
  assign bus_active   = avm_read | avm_write;
  assign unused_wdata = ^avm_writedata[31:10];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_active) begin
          req_d = bus_req;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        // A master that changes or withdraws its request abandons the transfer.
        if (!bus_active || (bus_req != req_q)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    avm_waitrequest = 1'b1;
    commit          = 1'b0;
    if (state_q == ST_ACK) begin
      avm_waitrequest = 1'b0;
      commit          = 1'b1;
    end
    enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
  end

  // Read data and the pop decision are captured together when ACK is entered,
  // so a byte arriving during ACK cannot be popped without being returned.
  always_comb begin
    read_value = '0;
    if (req_d.rd) begin
      case (req_d.addr)
        RX_BASE:     read_value = rx_empty ? 32'h0 : {24'h0, rx_head};
        STATUS_BASE: read_value = status_word(!rx_empty, !tx_full, rx_ovf_q, tx_ovf_q);
        default:     read_value = '0;
      endcase
    end
    readdata_d = enter_ack ? read_value : readdata_q;
    rx_pop_d   = enter_ack ? (req_d.rd && (req_d.addr == RX_BASE) && !rx_empty) : rx_pop_q;
  end

  assign wr_commit = commit && !req_q.rd && req_q.wr;
  assign tx_push   = wr_commit && (req_q.addr == TX_BASE);
  assign stat_clr  = wr_commit && (req_q.addr == STATUS_BASE);
  assign rx_pop    = commit && rx_pop_q;
  assign rx_push   = rx_valid && !rx_full;
  assign tx_pop    = tx_ready && !tx_empty;

  // Sticky overflow flags: a set in the same cycle as a clear wins.
  always_comb begin
    rx_ovf_d = (rx_valid && rx_full) ||
               (rx_ovf_q && !(stat_clr && avm_writedata[RX_OVF_BIT]));
    tx_ovf_d = (tx_push && tx_full) ||
               (tx_ovf_q && !(stat_clr && avm_writedata[TX_OVF_BIT]));
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      readdata_q <= '0;
      rx_pop_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      rx_pop_q   <= rx_pop_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (avm_clk),
    .rst_i   (avm_rst),
    .push_i  (rx_push),
    .data_i  (rx_data),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (avm_clk),
    .rst_i   (avm_rst),
    .push_i  (tx_push),
    .data_i  (avm_writedata[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  assign avm_readdata = readdata_q;
  assign rx_ready     = !rx_full;
  assign tx_valid     = !tx_empty;
  assign tx_data      = tx_head;

endmodule
